reg_writeback_unit: RTL
=======================

// Module: reg_writeback_unit
// PURPOSE
//  MEM/WB pipeline stage that drives the register file write port (WB, writeReg, writeData).
//  Selects ALU result or load data, and suppresses writes to $0.
//  The register file registers its read data on the same edge it writes, so a same-edge read
//  returns stale data; this block bypasses that stale data on the read-data path.
//  Also counts retired register writes for debug and verification.
// PARAMETERS
//  DATA_W  32  register / data width
//  ADDR_W  5   register index width
//  CNT_W   16  width of retired-write counter
// PORTS
//  clk            in   1       single clock; all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  stall          in   1       1 = MEM stage holding; WB stage takes a bubble
//  mem_valid      in   1       MEM stage holds a real instruction
//  mem_RegWrite   in   1       instruction writes a register
//  mem_MemtoReg   in   1       1 = write load data, 0 = write ALU result
//  mem_writeReg   in   ADDR_W  destination register
//  mem_ALUResult  in   DATA_W  ALU result
//  mem_ReadData   in   DATA_W  data-memory load data
//  WB             out  1       register file write enable
//  writeReg       out  ADDR_W  register file write index
//  writeData      out  DATA_W  register file write data
//  readReg1       in   ADDR_W  read index 1, same value the register file sees this cycle
//  readReg2       in   ADDR_W  read index 2, same value the register file sees this cycle
//  RegData1_rf    in   DATA_W  registered read data 1 from the register file
//  RegData2_rf    in   DATA_W  registered read data 2 from the register file
//  RegData1       out  DATA_W  corrected read data 1 for the decode stage
//  RegData2       out  DATA_W  corrected read data 2 for the decode stage
//  wb_count       out  CNT_W   number of cycles with WB=1, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, any time):
//   - WB=0, writeReg=0, writeData=0, wb_count=0.
//   - Both bypass hit flags=0 and both bypass data regs=0.
//   - A write pending in the stage is discarded and never reaches the register file.
//  Stage register, posedge, stall=0:
//   - WB        <= mem_valid & mem_RegWrite & (mem_writeReg!=0).
//   - writeReg  <= mem_writeReg.
//   - writeData <= mem_MemtoReg ? mem_ReadData : mem_ALUResult.
//   - Latency: exactly 1 cycle from MEM inputs to write-port outputs.
//  Stall, posedge, stall=1:
//   - WB <= 0 (bubble); writeReg and writeData hold.
//   - The held MEM instruction is re-presented later, so it is written exactly once.
//  Bypass, for each read port n (1 and 2), on every posedge:
//   - hit_n  <= WB & (writeReg==readReg_n) & (readReg_n!=0).
//   - data_n <= writeData.
//   - RegData_n = hit_n ? data_n : RegData_n_rf (combinational mux).
//   - Both ports may hit the same write in the same cycle; both get the new data.
//   - readReg_n==0 never hits, so RegData_n passes RegData_n_rf through (always 0).
//   - The bypass ignores stall: it tracks the actual write-port activity each edge.
//  Counter:
//   - wb_count += 1 on each posedge where WB==1; wraps from 2^CNT_W-1 to 0.
//  Mid-operation reset:
//   - Outputs are 0 from reset assertion onward; the first write appears 1 edge after the
//     first posedge with rst=0 and a qualifying MEM instruction.
// TESTING
//  T1:
//   - Stimulus: ALU write r5=0x1234 (MemtoReg=0, valid, RegWrite).
//   - Response: next cycle WB=1, writeReg=5, writeData=0x1234; wb_count=1 after that edge.
//  T2:
//   - Stimulus: load write r7, MemtoReg=1, ReadData=0xDEADBEEF, ALUResult=0x40.
//   - Response: writeData=0xDEADBEEF.
//  T3:
//   - Stimulus: write to r0 (value 0xFF) with valid=1, RegWrite=1.
//   - Response: WB=0; wb_count unchanged; RegData1 for readReg1=0 stays 0.
//  T4:
//   - Stimulus: WB=1 writes r20=50 while readReg1=readReg2=20 on the same edge; RegData_rf=old 0.
//   - Response: next cycle RegData1=RegData2=50.
//  T5:
//   - Stimulus: stall=1 for 3 cycles with a valid write to r3 presented.
//   - Response: WB=0 on all 3 cycles; after stall drops, exactly one WB=1 pulse; wb_count +1.
//  T6:
//   - Stimulus: assert rst while WB=1 for r9.
//   - Response: WB=0 immediately (async); r9 is not written; wb_count=0.
//   - Stimulus: set CNT_W=4 and retire 17 writes.
//   - Response: wb_count=1.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// MEM/WB stage driving the register file write port, with same-edge read bypass
// and a retired-write counter.
module reg_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic [ADDR_W-1:0] mem_writeReg,
  input  logic [DATA_W-1:0] mem_ALUResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              WB,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [DATA_W-1:0] RegData1_rf,
  input  logic [DATA_W-1:0] RegData2_rf,
  output logic [DATA_W-1:0] RegData1,
  output logic [DATA_W-1:0] RegData2,
  output logic [CNT_W-1:0]  wb_count
);

  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              hit1_q, hit1_d, hit2_q, hit2_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // NOTE: every signal gets a default before the conditional updates, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wb_d         = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (!stall) begin
      wb_d         = mem_valid & mem_RegWrite & (mem_writeReg != '0);
      write_reg_d  = mem_writeReg;
      write_data_d = mem_MemtoReg ? mem_ReadData : mem_ALUResult;
    end

    // The register file samples the current write on this edge; capture it
    // here so the stale registered read can be replaced next cycle.
    hit1_d  = wb_q & (write_reg_q == readReg1) & (readReg1 != '0);
    hit2_d  = wb_q & (write_reg_q == readReg2) & (readReg2 != '0);
    data1_d = write_data_q;
    data2_d = write_data_q;

    count_d = count_q + {{(CNT_W-1){1'b0}}, wb_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q         <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      count_q      <= '0;
    end else begin
      wb_q         <= wb_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      hit1_q       <= hit1_d;
      hit2_q       <= hit2_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      count_q      <= count_d;
    end
  end

  assign WB        = wb_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign RegData1  = hit1_q ? data1_q : RegData1_rf;
  assign RegData2  = hit2_q ? data2_q : RegData2_rf;
  assign wb_count  = count_q;

endmodule
